// File: rtl/i2c_slave_responder.sv
// I2C target: oversampled SCL/SDA, 7-bit address match, register-addressed
// write bursts and pointer-based read bursts against a small register file.
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDRESS          = 7'h68,
  parameter int         DATA_WIDTH             = 8,
  parameter int         REGISTER_ADDRESS_WIDTH = 8,
  parameter int         NO_OF_REG              = 4
) (
  input  logic                              pclk,
  input  logic                              areset,
  input  logic                              scl_i,
  input  logic                              sda_i,
  output logic                              sda_oe,
  output logic                              wr_strobe,
  output logic [REGISTER_ADDRESS_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]             wr_data,
  output logic                              busy,
  output logic [5:0]                        state
);

  localparam int IW = (NO_OF_REG > 1) ? $clog2(NO_OF_REG) : 1;

  typedef enum logic [5:0] {
    ST_IDLE      = 6'd0,
    ST_ADDR      = 6'd1,
    ST_ADDR_ACK  = 6'd2,
    ST_REG_ADDR  = 6'd3,
    ST_REG_ACK   = 6'd4,
    ST_WR_DATA   = 6'd5,
    ST_WR_ACK    = 6'd6,
    ST_RD_DATA   = 6'd7,
    ST_RD_ACK    = 6'd8,
    ST_WAIT_STOP = 6'd9
  } state_e;

  state_e                              state_q, state_d;
  logic                                scl_m_q, scl_s_q, scl_p_q;
  logic                                sda_m_q, sda_s_q, sda_p_q;
  logic [2:0]                          bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]               shift_q, shift_d;
  logic [IW-1:0]                       ptr_q, ptr_d;
  logic                                rw_q, rw_d;
  logic                                sda_oe_q, sda_oe_d;
  logic                                wr_strobe_q, wr_strobe_d;
  logic [REGISTER_ADDRESS_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]               wr_data_q, wr_data_d;
  logic                                busy_q;
  logic [DATA_WIDTH-1:0]               regs_q [NO_OF_REG];

  logic                  scl_rise_s, scl_fall_s, start_s, stop_s;
  logic                  byte_done_s, ack_done_s, addr_match_s, reg_ok_s;
  logic                  reg_we_s, load_rd_s;
  logic [DATA_WIDTH-1:0] byte_s, rd_byte_s;
  logic [IW-1:0]         ptr_next_s;

  // START/STOP need SCL stable high across the sample, so an SCL edge wins
  assign scl_rise_s   = scl_s_q & ~scl_p_q;
  assign scl_fall_s   = ~scl_s_q & scl_p_q;
  assign start_s      = scl_s_q & scl_p_q & sda_p_q & ~sda_s_q;
  assign stop_s       = scl_s_q & scl_p_q & ~sda_p_q & sda_s_q;
  assign byte_done_s  = scl_rise_s && (bit_cnt_q == 3'd7);
  assign ack_done_s   = scl_fall_s && (bit_cnt_q == 3'd2);
  assign byte_s       = {shift_q[DATA_WIDTH-2:0], sda_s_q};
  assign addr_match_s = (byte_s[DATA_WIDTH-1:1] == SLAVE_ADDRESS);
  assign reg_ok_s     = ({1'b0, byte_s} < (DATA_WIDTH+1)'(NO_OF_REG));
  assign rd_byte_s    = regs_q[ptr_q];
  assign ptr_next_s   = (ptr_q == IW'(NO_OF_REG - 1)) ? '0 : ptr_q + IW'(1);
  assign load_rd_s    = (state_q == ST_RD_ACK) || ((state_q == ST_ADDR_ACK) && rw_q);

  // State, synchronizers, datapath and registered outputs
  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      state_q     <= ST_IDLE;
      scl_m_q     <= 1'b1;
      scl_s_q     <= 1'b1;
      scl_p_q     <= 1'b1;
      sda_m_q     <= 1'b1;
      sda_s_q     <= 1'b1;
      sda_p_q     <= 1'b1;
      bit_cnt_q   <= 3'd0;
      shift_q     <= '0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      for (int i = 0; i < NO_OF_REG; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      scl_m_q     <= scl_i;
      scl_s_q     <= scl_m_q;
      scl_p_q     <= scl_s_q;
      sda_m_q     <= sda_i;
      sda_s_q     <= sda_m_q;
      sda_p_q     <= sda_s_q;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= (state_d != ST_IDLE);
      if (reg_we_s) regs_q[ptr_q] <= byte_s;
    end
  end

  // Next-state logic; bus conditions override every state
  always_comb begin
    state_d = state_q;
    if (start_s) begin
      state_d = ST_ADDR;
    end else if (stop_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_WAIT_STOP: state_d = state_q;
        ST_ADDR:     state_d = byte_done_s ? (addr_match_s ? ST_ADDR_ACK : ST_WAIT_STOP) : ST_ADDR;
        ST_ADDR_ACK: state_d = ack_done_s ? (rw_q ? ST_RD_DATA : ST_REG_ADDR) : ST_ADDR_ACK;
        ST_REG_ADDR: state_d = byte_done_s ? (reg_ok_s ? ST_REG_ACK : ST_WAIT_STOP) : ST_REG_ADDR;
        ST_REG_ACK:  state_d = ack_done_s ? ST_WR_DATA : ST_REG_ACK;
        ST_WR_DATA:  state_d = byte_done_s ? ST_WR_ACK : ST_WR_DATA;
        ST_WR_ACK:   state_d = ack_done_s ? ST_WR_DATA : ST_WR_ACK;
        ST_RD_DATA:  state_d = byte_done_s ? ST_RD_ACK : ST_RD_DATA;
        ST_RD_ACK: begin
          if (scl_rise_s && sda_s_q) state_d = ST_WAIT_STOP;
          else if (ack_done_s)       state_d = ST_RD_DATA;
          else                       state_d = ST_RD_ACK;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Bit counting, shifting, pointer, register writes and SDA drive
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    reg_we_s    = 1'b0;
    if (start_s || stop_s) begin
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_REG_ADDR, ST_WR_DATA: begin
          if (scl_rise_s) begin
            shift_d   = byte_s;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (byte_done_s) begin
              case (state_q)
                ST_ADDR:     rw_d = sda_s_q;
                ST_REG_ADDR: ptr_d = reg_ok_s ? byte_s[IW-1:0] : ptr_q;
                ST_WR_DATA: begin
                  reg_we_s    = 1'b1;
                  wr_strobe_d = 1'b1;
                  wr_addr_d   = REGISTER_ADDRESS_WIDTH'(ptr_q);
                  wr_data_d   = byte_s;
                  ptr_d       = ptr_next_s;
                end
                default: rw_d = rw_q;
              endcase
            end else begin
              rw_d = rw_q;
            end
          end else begin
            bit_cnt_d = bit_cnt_q;
          end
        end
        ST_RD_DATA: begin
          if (scl_rise_s) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else if (scl_fall_s) begin
            shift_d  = {shift_q[DATA_WIDTH-2:0], shift_q[DATA_WIDTH-1]};
            sda_oe_d = ~shift_q[DATA_WIDTH-2];
          end else begin
            bit_cnt_d = bit_cnt_q;
          end
        end
        // ACK slots: 0 = awaiting fall into slot, 1 = slot low, 2 = slot high
        ST_ADDR_ACK, ST_REG_ACK, ST_WR_ACK, ST_RD_ACK: begin
          if (scl_fall_s && (bit_cnt_q == 3'd0)) begin
            bit_cnt_d = 3'd1;
            sda_oe_d  = (state_q != ST_RD_ACK);
          end else if (scl_rise_s) begin
            bit_cnt_d = 3'd2;
            ptr_d     = ((state_q == ST_RD_ACK) && !sda_s_q) ? ptr_next_s : ptr_q;
          end else if (ack_done_s) begin
            bit_cnt_d = 3'd0;
            if (load_rd_s) begin
              shift_d  = rd_byte_s;
              sda_oe_d = ~rd_byte_s[DATA_WIDTH-1];
            end else begin
              sda_oe_d = 1'b0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q;
          end
        end
        ST_WAIT_STOP: sda_oe_d = 1'b0;
        default:      sda_oe_d = sda_oe_q;
      endcase
    end
  end

  assign sda_oe    = sda_oe_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign state     = state_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: bit-banged I2C master, register-file model,
// and a write-strobe scoreboard checked by an independent monitor.
module tb_i2c_slave_responder;
  localparam int Q = 4;  // pclk cycles per quarter SCL period

  logic       pclk = 1'b0;
  logic       areset = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe, wr_strobe, busy;
  logic [7:0] wr_addr, wr_data;
  logic [5:0] state;

  assign sda_line = sda_m & ~sda_oe;

  i2c_slave_responder dut (
    .pclk(pclk), .areset(areset), .scl_i(scl_m), .sda_i(sda_line),
    .sda_oe(sda_oe), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .state(state)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int passes = 0;

  typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
  wr_t        exp_wr[$];
  logic [7:0] txq[$];
  logic [7:0] mreg[4];
  int         mptr = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Monitor: every committed write must match the oldest expected one
  always @(negedge pclk) begin
    if (areset && wr_strobe) begin
      if (exp_wr.size() == 0) begin
        checks++;
        $display("FAIL unexpected_strobe: got addr 0x%0h data 0x%0h expected none", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        check("wr_addr", wr_addr, e.a);
        check("wr_data", wr_data, e.d);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic bus_start();
    if (scl_m == 1'b0) begin
      tick(Q); sda_m = 1'b1; tick(Q); scl_m = 1'b1;
    end
    tick(Q); sda_m = 1'b0; tick(Q); scl_m = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic bus_stop();
    tick(Q); sda_m = 1'b0; tick(Q); scl_m = 1'b1; tick(Q); sda_m = 1'b1; tick(Q);
    check("busy_after_stop", busy, 0);
    check("idle_after_stop", state, 0);
  endtask

  task automatic clock_bit(input logic b, output logic line, output logic oe);
    tick(Q); sda_m = b; tick(Q); scl_m = 1'b1; tick(Q);
    line = sda_line; oe = sda_oe;
    tick(Q); scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string name);
    logic l, o;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], l, o);
    clock_bit(1'b1, l, o);
    check(name, o, exp_ack);
  endtask

  task automatic recv_byte(input logic [7:0] exp, input logic ack, input string name);
    logic [7:0] got;
    logic l, o;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, l, o);
      got[i] = l;
    end
    check(name, got, exp);
    clock_bit(~ack, l, o);
    check("rd_ack_released", o, 0);
  endtask

  // Write: address, register byte, then every byte queued in txq
  task automatic write_txn(input logic [6:0] a7, input logic [7:0] ra, input logic do_stop);
    logic match, ok;
    match = (a7 == 7'h68);
    ok    = match && (ra < 8'd4);
    bus_start();
    send_byte({a7, 1'b0}, match, "addr_ack");
    send_byte(ra, ok, "reg_ack");
    if (ok) mptr = int'(ra);
    foreach (txq[i]) begin
      if (ok) begin
        exp_wr.push_back('{a: 8'(mptr), d: txq[i]});
        mreg[mptr] = txq[i];
        mptr = (mptr + 1) % 4;
      end
      send_byte(txq[i], ok, "data_ack");
    end
    if (do_stop) bus_stop();
  endtask

  // Read n bytes from the retained pointer; the last byte is NACKed
  task automatic read_txn(input logic [6:0] a7, input int n);
    logic match;
    match = (a7 == 7'h68);
    bus_start();
    send_byte({a7, 1'b1}, match, "rd_addr_ack");
    if (match) begin
      for (int i = 0; i < n; i++) begin
        logic [7:0] e;
        e = mreg[mptr];
        recv_byte(e, i != n - 1, "rd_data");
        if (i != n - 1) mptr = (mptr + 1) % 4;
      end
      check("wait_stop_after_nack", state, 9);
    end
    bus_stop();
  endtask

  initial begin
    logic l, o;
    foreach (mreg[i]) mreg[i] = 8'h00;
    tick(3);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_wr_strobe", wr_strobe, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state, 0);
    areset = 1'b1;
    tick(4);

    txq = '{8'hA5};        write_txn(7'h68, 8'h01, 1'b1);
    txq = '{8'h11, 8'h22}; write_txn(7'h68, 8'h03, 1'b1);
    txq.delete();          write_txn(7'h68, 8'h01, 1'b0);
    read_txn(7'h68, 2);
    txq = '{8'h55};        write_txn(7'h6C, 8'h00, 1'b1);
    txq = '{8'h77};        write_txn(7'h68, 8'h04, 1'b1);

    for (int t = 0; t < 24; t++) begin
      logic [6:0] a7;
      int kind;
      kind = $urandom_range(0, 9);
      a7 = 7'h68;
      if (kind == 0) begin
        a7 = 7'($urandom_range(0, 127));
        if (a7 == 7'h68) a7 = 7'h69;
      end
      if (kind < 5) begin
        txq.delete();
        repeat ($urandom_range(0, 3)) txq.push_back(8'($urandom));
        write_txn(a7, 8'($urandom_range(0, 5)), 1'b1);
      end else begin
        if (kind > 7) begin
          txq.delete();
          write_txn(7'h68, 8'($urandom_range(0, 4)), 1'b0);
        end
        read_txn(a7, $urandom_range(1, 4));
      end
    end

    // Reset while the target is pulling SDA low during a read
    txq = '{8'h3C}; write_txn(7'h68, 8'h00, 1'b1);
    txq.delete();   write_txn(7'h68, 8'h00, 1'b1);
    bus_start();
    send_byte(8'hD1, 1'b1, "rd_addr_ack");
    clock_bit(1'b1, l, o);
    check("rd_drive_low", o, 1);
    areset = 1'b0;
    #1;
    check("async_rst_sda_oe", sda_oe, 0);
    check("async_rst_state", state, 0);
    check("async_rst_busy", busy, 0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    tick(4);
    areset = 1'b1;
    foreach (mreg[i]) mreg[i] = 8'h00;
    mptr = 0;
    tick(4);
    read_txn(7'h68, 4);

    tick(10);
    check("strobes_outstanding", exp_wr.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
